canny_threshold_classify: RTL and testbench

- Producer side of the Canny 2-bit edge-class stream; sits between non-maximum suppression and the double-threshold/hysteresis stage.
- Classifies each suppressed 8-bit gradient magnitude into max_g: 00 none, 01 weak, 10 strong.
- Thresholds are either static (from configuration inputs) or adaptive.
- In adaptive mode, thresholds are derived from a 16-bin magnitude histogram of the previous frame and applied at the next frame start.

---
 rtl/canny_threshold_classify.sv | 207 ++++++++++++++++++++
 tb/tb_canny_threshold_classify.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/canny_threshold_classify.sv
// canny_threshold_classify
//   Sits between non-maximum suppression and the hysteresis stage. Each valid
//   pixel magnitude is sorted into none / weak / strong against the active
//   high/low thresholds. Thresholds come either from cfg_high/cfg_low or, in
//   adaptive mode, from a 16-bin histogram of the previous frame. That
//   histogram is scanned from the top bin down after the frame ends.
//
// Ports
//   clk               pixel clock
//   rst_s             synchronous active-high reset
//   pre_frame_vsync   frame valid (high during the frame)
//   pre_frame_href    line valid
//   pre_frame_clken   pixel valid
//   pre_mag[7:0]      suppressed gradient magnitude
//   thresh_auto       1 = adaptive thresholds, 0 = cfg_high/cfg_low
//   cfg_high[7:0]     static high threshold
//   cfg_low[7:0]      static low threshold
//   post_frame_*      pre_frame_* delayed one cycle
//   max_g[1:0]        edge class: 00 none, 01 weak, 10 strong
//   act_high/act_low  thresholds currently in use
//   frame_overrun     one-cycle pulse when a new frame aborts a running scan
//
// FSM
//   state | meaning
//   IDLE  | waiting for the end of a frame (vsync falling edge)
//   SCAN  | walking bins 15..0, accumulating counts until the target is passed
//   DONE  | commit the scan result into the shadow thresholds
module canny_threshold_classify #(
  parameter int         CNT_W        = 20,
  parameter int         RATIO_SHIFT  = 3,
  parameter logic [7:0] DEFAULT_HIGH = 8'h60,
  parameter logic [7:0] DEFAULT_LOW  = 8'h30
) (
  input  logic       clk,
  input  logic       rst_s,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_href,
  input  logic       pre_frame_clken,
  input  logic [7:0] pre_mag,
  input  logic       thresh_auto,
  input  logic [7:0] cfg_high,
  input  logic [7:0] cfg_low,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [1:0] max_g,
  output logic [7:0] act_high,
  output logic [7:0] act_low,
  output logic       frame_overrun
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic             vsync_d;
  logic             vs_rise, vs_fall;
  logic             hist_en;
  logic [CNT_W-1:0] bin [16];
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] accum;
  logic [CNT_W:0]   accum_sum;
  logic [CNT_W-1:0] accum_n;
  logic             scan_hit;
  logic [3:0]       idx;
  logic [7:0]       cand_high, cand_low;
  logic [7:0]       shadow_high, shadow_low;
  logic             overrun_nxt;
  logic             href_d, clken_d;
  logic [1:0]       class_nxt;

  // vsync_d doubles as the delayed vsync output
  assign post_frame_vsync = vsync_d;
  assign post_frame_href  = href_d;
  assign post_frame_clken = clken_d;

  assign vs_rise = pre_frame_vsync & ~vsync_d;
  assign vs_fall = ~pre_frame_vsync & vsync_d;
  assign hist_en = pre_frame_vsync & pre_frame_href & pre_frame_clken;

  // Saturating running sum of the bins visited so far, top bin first
  assign accum_sum = {1'b0, accum} + {1'b0, bin[idx]};
  assign accum_n   = accum_sum[CNT_W] ? '1 : accum_sum[CNT_W-1:0];
  assign scan_hit  = accum_n > target;

  // Strong wins over weak, which also covers act_low > act_high
  always_comb begin
    class_nxt = 2'b00;
    if (pre_frame_clken && pre_frame_href) begin
      if (pre_mag >= act_high)     class_nxt = 2'b10;
      else if (pre_mag >= act_low) class_nxt = 2'b01;
    end
  end

  always_comb begin
    state_nxt   = state;
    overrun_nxt = 1'b0;
    case (state)
      IDLE: if (vs_fall) state_nxt = SCAN;
      SCAN: begin
        if (vs_rise) begin
          state_nxt   = IDLE;
          overrun_nxt = 1'b1;
        end else if (scan_hit || idx == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_s) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pixel pipeline and threshold selection
  always_ff @(posedge clk) begin
    if (rst_s) begin
      vsync_d       <= 1'b0;
      href_d        <= 1'b0;
      clken_d       <= 1'b0;
      max_g         <= 2'b00;
      act_high      <= DEFAULT_HIGH;
      act_low       <= DEFAULT_LOW;
      frame_overrun <= 1'b0;
    end else begin
      vsync_d       <= pre_frame_vsync;
      href_d        <= pre_frame_href;
      clken_d       <= pre_frame_clken;
      max_g         <= class_nxt;
      frame_overrun <= overrun_nxt;
      if (vs_rise) begin
        act_high <= thresh_auto ? shadow_high : cfg_high;
        act_low  <= thresh_auto ? shadow_low  : cfg_low;
      end
    end
  end

  // Histogram: cleared on frame start, saturating counts otherwise
  always_ff @(posedge clk) begin
    if (rst_s) begin
      for (int i = 0; i < 16; i++) bin[i] <= '0;
      total <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (vs_rise)
          bin[i] <= '0;
        else if (hist_en && pre_mag[7:4] == i[3:0] && bin[i] != '1)
          bin[i] <= bin[i] + ONE;
      end
      if (vs_rise)
        total <= '0;
      else if (hist_en && total != '1)
        total <= total + ONE;
    end
  end

  // Scan datapath. The result is parked in cand_* and only copied to the
  // shadow registers in DONE, so a frame start coinciding with DONE still
  // picks up the previous shadow values.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      target      <= '0;
      accum       <= '0;
      idx         <= 4'd15;
      cand_high   <= DEFAULT_HIGH;
      cand_low    <= DEFAULT_LOW;
      shadow_high <= DEFAULT_HIGH;
      shadow_low  <= DEFAULT_LOW;
    end else begin
      case (state)
        IDLE: begin
          if (vs_fall) begin
            target <= total >> RATIO_SHIFT;
            idx    <= 4'd15;
            accum  <= '0;
          end
        end
        SCAN: begin
          if (!vs_rise) begin
            accum <= accum_n;
            if (scan_hit) begin
              cand_high <= {idx, 4'h0};
              cand_low  <= {1'b0, idx, 3'h0};
            end else if (idx == 4'd0) begin
              cand_high <= DEFAULT_HIGH;
              cand_low  <= DEFAULT_LOW;
            end else begin
              idx <= idx - 4'd1;
            end
          end
        end
        DONE: begin
          shadow_high <= cand_high;
          shadow_low  <= cand_low;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_canny_threshold_classify.sv
module tb_canny_threshold_classify;

  logic       clk = 1'b0;
  logic       rst_s = 1'b1;
  logic       vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [7:0] mag = 8'h00;
  logic       ta = 1'b0;
  logic [7:0] ch = 8'h00, cl = 8'h00;

  logic       a_vs, a_hr, a_ce, a_ovr, b_vs, b_hr, b_ce, b_ovr;
  logic [1:0] a_g, b_g;
  logic [7:0] a_h, a_l, b_h, b_l;

  always #5 clk = ~clk;

  canny_threshold_classify #(.CNT_W(20)) dut_a (
    .clk(clk), .rst_s(rst_s), .pre_frame_vsync(vs), .pre_frame_href(hr),
    .pre_frame_clken(ce), .pre_mag(mag), .thresh_auto(ta), .cfg_high(ch),
    .cfg_low(cl), .post_frame_vsync(a_vs), .post_frame_href(a_hr),
    .post_frame_clken(a_ce), .max_g(a_g), .act_high(a_h), .act_low(a_l),
    .frame_overrun(a_ovr));

  canny_threshold_classify #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_s(rst_s), .pre_frame_vsync(vs), .pre_frame_href(hr),
    .pre_frame_clken(ce), .pre_mag(mag), .thresh_auto(ta), .cfg_high(ch),
    .cfg_low(cl), .post_frame_vsync(b_vs), .post_frame_href(b_hr),
    .post_frame_clken(b_ce), .max_g(b_g), .act_high(b_h), .act_low(b_l),
    .frame_overrun(b_ovr));

  int total = 0;
  int bad = 0;

  // Reference model: raw per-frame counts, thresholds per instance (0: W=20, 1: W=4)
  int         hist [16];
  int         tot;
  int         width [2] = '{20, 4};
  logic [7:0] sh_h [2], sh_l [2], ah [2], al [2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cls(input logic [7:0] m, input logic [7:0] h, input logic [7:0] l);
    if (m >= h) return 2'b10;
    if (m >= l) return 2'b01;
    return 2'b00;
  endfunction

  // Strong target = top 1/8 of the (saturated) pixel count; walk bins from the
  // top, first bin whose cumulative count exceeds the target sets high = bin*16.
  task automatic scan_model(input int k);
    int maxv, t, acc, c;
    bit found;
    maxv  = (1 << width[k]) - 1;
    t     = ((tot > maxv) ? maxv : tot) >> 3;
    acc   = 0;
    found = 0;
    for (int i = 15; i >= 0 && !found; i--) begin
      c   = (hist[i] > maxv) ? maxv : hist[i];
      acc = acc + c;
      if (acc > maxv) acc = maxv;
      if (acc > t) begin
        sh_h[k] = 8'(i * 16);
        sh_l[k] = 8'(i * 8);
        found   = 1;
      end
    end
    if (!found) begin
      sh_h[k] = 8'h60;
      sh_l[k] = 8'h30;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sh_h[k] = 8'h60; sh_l[k] = 8'h30; ah[k] = 8'h60; al[k] = 8'h30;
    end
    for (int i = 0; i < 16; i++) hist[i] = 0;
    tot = 0;
  endtask

  task automatic do_reset();
    vs = 1'b1; hr = 1'b1; ce = 1'b1; mag = 8'hFF;
    rst_s = 1'b1;
    step();
    step();
    model_reset();
    chk("rst_post_vsync", {7'd0, a_vs}, 8'h00);
    chk("rst_post_href", {7'd0, a_hr}, 8'h00);
    chk("rst_post_clken", {7'd0, a_ce}, 8'h00);
    chk("rst_max_g", {6'd0, a_g}, 8'h00);
    chk("rst_overrun", {7'd0, a_ovr}, 8'h00);
    chk("rst_act_high", a_h, 8'h60);
    chk("rst_act_low", a_l, 8'h30);
    chk("rst_b_act_high", b_h, 8'h60);
    rst_s = 1'b0; vs = 1'b0; hr = 1'b0; ce = 1'b0;
    step();
  endtask

  task automatic start_frame(input bit ovr);
    vs = 1'b1; hr = 1'b0; ce = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      ah[k] = ta ? sh_h[k] : ch;
      al[k] = ta ? sh_l[k] : cl;
    end
    for (int i = 0; i < 16; i++) hist[i] = 0;
    tot = 0;
    chk("act_high", a_h, ah[0]);
    chk("act_low", a_l, al[0]);
    chk("b_act_high", b_h, ah[1]);
    chk("b_act_low", b_l, al[1]);
    chk("overrun", {7'd0, a_ovr}, {7'd0, ovr});
    chk("b_overrun", {7'd0, b_ovr}, {7'd0, ovr});
  endtask

  task automatic pixel(input logic [7:0] m);
    vs = 1'b1; hr = 1'b1; ce = 1'b1; mag = m;
    step();
    hist[m >> 4]++;
    tot++;
    chk("max_g", {6'd0, a_g}, {6'd0, cls(m, ah[0], al[0])});
    chk("b_max_g", {6'd0, b_g}, {6'd0, cls(m, ah[1], al[1])});
    chk("post_clken", {7'd0, a_ce}, 8'h01);
    chk("post_href", {7'd0, a_hr}, 8'h01);
    chk("post_vsync", {7'd0, a_vs}, 8'h01);
    chk("overrun_idle", {7'd0, a_ovr}, 8'h00);
  endtask

  // Close the frame and idle w cycles after the vsync fall; 17+ lets the scan commit.
  task automatic end_frame(input int w);
    hr = 1'b0; ce = 1'b0;
    step();
    chk("max_g_blank", {6'd0, a_g}, 8'h00);
    vs = 1'b0;
    step();
    chk("post_vsync_low", {7'd0, a_vs}, 8'h00);
    repeat (w) step();
    if (w >= 17) begin
      scan_model(0);
      scan_model(1);
    end
  endtask

  initial begin
    int n;
    model_reset();
    do_reset();

    // Static thresholds
    ta = 1'b0; ch = 8'h80; cl = 8'h40;
    start_frame(1'b0);
    pixel(8'h80); pixel(8'h7F); pixel(8'h40); pixel(8'h3F);
    end_frame(20);

    // Adaptive, 64-pixel frame
    ta = 1'b1;
    start_frame(1'b0);
    repeat (8) pixel(8'hF5);
    repeat (8) pixel(8'h85);
    repeat (48) pixel(8'h10);
    end_frame(20);

    // Empty frame
    start_frame(1'b0);
    repeat (10) step();
    end_frame(20);

    // Long scan interrupted 5 cycles after the fall
    start_frame(1'b0);
    repeat (64) pixel(8'h05);
    repeat (4) pixel(8'h35);
    end_frame(4);
    start_frame(1'b1);
    repeat (4) pixel(8'h35);
    end_frame(20);

    // Saturation (instance b has 4-bit counters)
    start_frame(1'b0);
    repeat (20) pixel(8'hFF);
    end_frame(20);
    start_frame(1'b0);
    repeat (20) pixel(8'h05);
    pixel(8'hFF);
    end_frame(20);
    start_frame(1'b0);

    // Reset in the middle of a scan discards it
    repeat (8) pixel(8'h05);
    end_frame(3);
    do_reset();
    start_frame(1'b0);
    end_frame(20);

    // Random frames, random mode/cfg, plus one with low > high
    for (int f = 0; f < 8; f++) begin
      ta = 1'($urandom_range(1, 0));
      ch = 8'($urandom_range(255, 0));
      cl = 8'($urandom_range(255, 0));
      if (f == 3) begin ta = 1'b0; ch = 8'h20; cl = 8'h90; end
      start_frame(1'b0);
      n = $urandom_range(80, 1);
      for (int p = 0; p < n; p++) pixel(8'($urandom_range(255, 0)));
      end_frame(20);
    end
    ta = 1'b1;
    start_frame(1'b0);
    end_frame(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
